mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, fixed-latency memory between three requesters: processor instruction fetch (IF), processor load/store (LS) and an external debug/DMA port (EXT). Sits between the processor core and the unified memory. It replaces the dual-port test memory so a single physical RAM can serve both the fetch and data paths. The core stalls on its own request until the matching ack.

## Interface
Parameters:
- `AW`, 30, word-address width (byte address / 4).
- `DW`, 32, data width.
- `MemLatency`, 1, cycles from `mem_en` to valid `mem_rdata`; legal 1–15.
- `MaxWait`, 8, cycles EXT may wait before it is promoted to top priority; legal 1–255.

Ports:
- `clk`, in, 1: single clock, all state on rising edge.
- `RESET`, in, 1: synchronous, active-high.
- `if_req`, in, 1: IF request (read only).
- `if_addr`, in, AW: IF word address.
- `if_ack`, out, 1: one-cycle pulse; `rdata` valid.
- `ls_req`, `ls_we`, in, 1 each: LS request and write enable.
- `ls_addr`, in, AW: LS word address.
- `ls_wdata`, in, DW: LS write data.
- `ls_ack`, out, 1: one-cycle completion pulse.
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_ack`: same as LS, for EXT.
- `rdata`, out, DW: read data, valid in the cycle of any ack; holds last value otherwise.
- `mem_en`, `mem_we`, out, 1 each: memory strobe and write enable.
- `mem_addr`, out, AW: memory address.
- `mem_wdata`, out, DW: memory write data.
- `mem_rdata`, in, DW: memory read data.
- `busy`, out, 1: FSM not in IDLE.
- `owner`, out, 2: current grant; 0=none, 1=IF, 2=LS, 3=EXT.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is asserted, arbitrate, latch the winner's address, `we` and `wdata`, set `owner`, then go to ISSUE. With no request, stay in IDLE.
- Arbitration priority:
  - If `ext_wait` equals `MaxWait`: EXT first, then LS, then IF.
  - Otherwise: LS first, then IF, then EXT.
- ISSUE: drive `mem_en`=1 for exactly one cycle using the latched `we`, `addr` and `wdata`. Load the latency counter with `MemLatency`-1. Go to WAIT, or go straight to RESP when `MemLatency`=1.
- WAIT: decrement the counter each cycle; at 0, go to RESP.
- RESP: `mem_rdata` is valid. Register it into `rdata`, pulse the owner's ack for one cycle, clear `owner`, return to IDLE.
- Writes follow the same path and ack the same way; `rdata` is still loaded from `mem_rdata`, and its value is don't-care for writes.
- Requesters hold `req`, `addr`, `we` and `wdata` until ack. Inputs are sampled only in IDLE, so later changes do not affect an in-flight access.
- A `req` dropped after grant still completes and acks; requesters must ignore the unwanted ack.
- `ext_wait`: 8-bit counter.
  - Increments each cycle `ext_req`=1 and EXT is not the owner.
  - Saturates at `MaxWait`.
  - Clears when EXT is granted or when `ext_req`=0.
- IF, LS and EXT do not time out. IF may starve while LS is continuously requesting; this is by design, since the core issues at most one LS per instruction.

## Timing
- Reset values, one cycle after `RESET` is sampled high:
  - state IDLE; `mem_en`=0, `mem_we`=0.
  - all acks 0, `busy`=0, `owner`=0, `ext_wait`=0.
  - `rdata`, `mem_addr` and `mem_wdata` = 0.
- Reset mid-access aborts it: no ack is issued, and the late `mem_rdata` is ignored.
- Request sampled in IDLE at cycle T:
  - `mem_en` is high in cycle T+1.
  - Ack and valid `rdata` occur in cycle T+1+`MemLatency`.
  - With `MemLatency`=1, ack is at T+2.
- Next arbitration happens in the cycle after ack, at T+2+`MemLatency`. Throughput is one access per `MemLatency`+2 cycles.
- Exactly one ack pulse per grant; no two acks in the same cycle.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable from ISSUE through RESP.

## Test plan
- Reset, then `if_req`=1 with `if_addr`=0x20000000 and `mem_rdata` model returning addr^0xA5A5A5A5, `MemLatency`=1 → `mem_en` at T+1, `if_ack` at T+2, `rdata`=0xA5A5A5A5 ^ 0x20000000.
- `if_req` and `ls_req` (write, `ls_addr`=0x10, `ls_wdata`=0xDEADBEEF) asserted together → LS is granted first; `mem_we`=1, `mem_addr`=0x10; `ls_ack` at T+2, `if_ack` at T+5.
- `MemLatency`=4, single EXT read → `ext_ack` exactly 5 cycles after sampling; `busy` high for 5 cycles; a single `mem_en` pulse.
- `ls_req` held high continuously plus `ext_req` high, `MaxWait`=8 → EXT is granted at the first IDLE after `ext_wait` reaches 8; `ext_wait` then clears and LS resumes.
- `RESET` asserted during WAIT (`MemLatency`=4) → no ack; `busy`=0 next cycle; a pending `if_req` is re-granted normally after reset deasserts.
- `if_req` dropped in the cycle after grant → `if_ack` still pulses at T+2, and the next IDLE cycle grants nothing.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between instruction fetch,
// load/store and an external debug/DMA port, one access in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned AW         = 30,
    parameter int unsigned DW         = 32,
    parameter int unsigned MemLatency = 1,
    parameter int unsigned MaxWait    = 8
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ack,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    owner
);

    localparam int unsigned CntW  = 4;
    localparam int unsigned WaitW = 8;
    localparam logic [1:0] OwnNone = 2'd0;
    localparam logic [1:0] OwnIf   = 2'd1;
    localparam logic [1:0] OwnLs   = 2'd2;
    localparam logic [1:0] OwnExt  = 2'd3;
    localparam logic [CntW-1:0]  CntLoad = CntW'(MemLatency - 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WaitW-1:0] ext_wait_q, ext_wait_d;
    logic             mem_en_q, mem_en_d;
    logic             busy_q, busy_d;
    logic             if_ack_q, if_ack_d;
    logic             ls_ack_q, ls_ack_d;
    logic             ext_ack_q, ext_ack_d;
    logic [1:0]       grant;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            owner_q    <= OwnNone;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            ext_wait_q <= '0;
            mem_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            if_ack_q   <= 1'b0;
            ls_ack_q   <= 1'b0;
            ext_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            ext_wait_q <= ext_wait_d;
            mem_en_q   <= mem_en_d;
            busy_q     <= busy_d;
            if_ack_q   <= if_ack_d;
            ls_ack_q   <= ls_ack_d;
            ext_ack_q  <= ext_ack_d;
        end
    end

    // Arbitration, next state and registered-output next values
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        ext_wait_d = ext_wait_q;
        mem_en_d   = 1'b0;
        if_ack_d   = 1'b0;
        ls_ack_d   = 1'b0;
        ext_ack_d  = 1'b0;
        grant      = OwnNone;

        if (ext_wait_q == WaitMax && ext_req) grant = OwnExt;
        else if (ls_req)                      grant = OwnLs;
        else if (if_req)                      grant = OwnIf;
        else if (ext_req)                     grant = OwnExt;

        case (state_q)
            S_IDLE: begin
                if (grant != OwnNone) begin
                    state_d  = S_ISSUE;
                    owner_d  = grant;
                    mem_en_d = 1'b1;
                    case (grant)
                        OwnIf: begin
                            we_d   = 1'b0;
                            addr_d = if_addr;
                        end
                        OwnLs: begin
                            we_d    = ls_we;
                            addr_d  = ls_addr;
                            wdata_d = ls_wdata;
                        end
                        default: begin
                            we_d    = ext_we;
                            addr_d  = ext_addr;
                            wdata_d = ext_wdata;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                cnt_d   = CntLoad;
                state_d = (CntLoad == '0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) state_d = S_RESP;
            end
            default: begin
                rdata_d = mem_rdata;
                owner_d = OwnNone;
                state_d = S_IDLE;
            end
        endcase

        // Ack is registered on entry to RESP so it lines up with valid mem_rdata
        if (state_d == S_RESP && state_q != S_RESP) begin
            if_ack_d  = (owner_q == OwnIf);
            ls_ack_d  = (owner_q == OwnLs);
            ext_ack_d = (owner_q == OwnExt);
        end

        if (!ext_req || (state_q == S_IDLE && grant == OwnExt)) begin
            ext_wait_d = '0;
        end else if (owner_q != OwnExt && ext_wait_q != WaitMax) begin
            ext_wait_d = ext_wait_q + WaitW'(1);
        end
    end

    assign busy_d = (state_d != S_IDLE);

    // mem_rdata is only valid during RESP, so it is passed through in the ack cycle
    assign rdata     = (state_q == S_RESP) ? mem_rdata : rdata_q;
    assign if_ack    = if_ack_q;
    assign ls_ack    = ls_ack_q;
    assign ext_ack   = ext_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: instance A runs with one-cycle memory latency, instance B
// with four; each has a simple behavioural memory attached.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 30;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXW = 8;
    localparam int          LATA = 1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;

    logic          a_if_req, a_ls_req, a_ls_we, a_ext_req, a_ext_we;
    logic [AW-1:0] a_if_addr, a_ls_addr, a_ext_addr;
    logic [DW-1:0] a_ls_wdata, a_ext_wdata;
    logic          a_if_ack, a_ls_ack, a_ext_ack, a_mem_en, a_mem_we, a_busy;
    logic [DW-1:0] a_rdata, a_mem_wdata, a_mem_rdata;
    logic [AW-1:0] a_mem_addr;
    logic [1:0]    a_owner;

    logic          b_if_req, b_ls_req, b_ls_we, b_ext_req, b_ext_we;
    logic [AW-1:0] b_if_addr, b_ls_addr, b_ext_addr;
    logic [DW-1:0] b_ls_wdata, b_ext_wdata;
    logic          b_if_ack, b_ls_ack, b_ext_ack, b_mem_en, b_mem_we, b_busy;
    logic [DW-1:0] b_rdata, b_mem_wdata, b_mem_rdata;
    logic [AW-1:0] b_mem_addr;
    logic [1:0]    b_owner;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MemLatency(1), .MaxWait(MAXW)) u_dut_a (
        .clk(clk), .RESET(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack),
        .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_addr(a_ls_addr), .ls_wdata(a_ls_wdata), .ls_ack(a_ls_ack),
        .ext_req(a_ext_req), .ext_we(a_ext_we), .ext_addr(a_ext_addr), .ext_wdata(a_ext_wdata), .ext_ack(a_ext_ack),
        .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MemLatency(4), .MaxWait(MAXW)) u_dut_b (
        .clk(clk), .RESET(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata), .ls_ack(b_ls_ack),
        .ext_req(b_ext_req), .ext_we(b_ext_we), .ext_addr(b_ext_addr), .ext_wdata(b_ext_wdata), .ext_ack(b_ext_ack),
        .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory A: latency 1, writable over a small aliased window; bad pattern when not valid
    logic [DW-1:0] hw_a [512];
    logic [511:0]  hw_wr;
    logic          a_rd_v;
    logic [DW-1:0] a_rd_d;
    always @(posedge clk) begin
        a_rd_v <= a_mem_en;
        if (a_mem_en) begin
            a_rd_d <= hw_wr[a_mem_addr[8:0]] ? hw_a[a_mem_addr[8:0]]
                                              : ({2'b00, a_mem_addr} ^ 32'hA5A5A5A5);
            if (a_mem_we) begin
                hw_a[a_mem_addr[8:0]]  <= a_mem_wdata;
                hw_wr[a_mem_addr[8:0]] <= 1'b1;
            end
        end
    end
    assign a_mem_rdata = a_rd_v ? a_rd_d : 32'hBAD0BAD0;

    // Memory B: read-only pattern, four-stage delay line
    logic [3:0]    b_v;
    logic [DW-1:0] b_d [4];
    always @(posedge clk) begin
        b_v[0] <= b_mem_en;
        b_d[0] <= {2'b00, b_mem_addr} ^ 32'hA5A5A5A5;
        for (int i = 1; i < 4; i++) begin
            b_v[i] <= b_v[i-1];
            b_d[i] <= b_d[i-1];
        end
    end
    assign b_mem_rdata = b_v[3] ? b_d[3] : 32'hBAD0BAD0;

    logic [DW-1:0] model_mem [logic [AW-1:0]];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        {a_if_req, a_ls_req, a_ls_we, a_ext_req, a_ext_we} = '0;
        {a_if_addr, a_ls_addr, a_ext_addr, a_ls_wdata, a_ext_wdata} = '0;
        {b_if_req, b_ls_req, b_ls_we, b_ext_req, b_ext_we} = '0;
        {b_if_addr, b_ls_addr, b_ext_addr, b_ls_wdata, b_ext_wdata} = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({a_mem_en, a_mem_we, a_if_ack, a_ls_ack, a_ext_ack, a_busy, a_owner} !== 8'h00) begin
            failures++; $display("FAIL reset_ctrl_a: got %b want 00000000",
                {a_mem_en, a_mem_we, a_if_ack, a_ls_ack, a_ext_ack, a_busy, a_owner});
        end
        checks++;
        if ({a_rdata, a_mem_addr, a_mem_wdata} !== '0) begin
            failures++; $display("FAIL reset_data_a: rdata %h addr %h wdata %h want 0", a_rdata, a_mem_addr, a_mem_wdata);
        end
        checks++;
        if ({b_mem_en, b_mem_we, b_if_ack, b_ls_ack, b_ext_ack, b_busy, b_owner, b_rdata} !== '0) begin
            failures++; $display("FAIL reset_b: got ctrl %b rdata %h want 0",
                {b_mem_en, b_mem_we, b_if_ack, b_ls_ack, b_ext_ack, b_busy, b_owner}, b_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_if_read();
        a_if_req = 1'b1; a_if_addr = 30'h20000000;
        tick();
        checks++;
        if ({a_mem_en, a_mem_we, a_owner, a_if_ack} !== 5'b10010 || a_mem_addr !== 30'h20000000) begin
            failures++; $display("FAIL if_issue: en/we/owner/ack %b addr %h want 10010 addr 20000000",
                {a_mem_en, a_mem_we, a_owner, a_if_ack}, a_mem_addr);
        end
        tick();
        checks++;
        if (a_if_ack !== 1'b1 || a_rdata !== 32'h85A5A5A5) begin
            failures++; $display("FAIL if_ack: ack %b rdata %h want 1 85a5a5a5", a_if_ack, a_rdata);
        end
        a_if_req = 1'b0;
        tick();
        checks++;
        if (a_if_ack !== 1'b0 || a_busy !== 1'b0 || a_rdata !== 32'h85A5A5A5) begin
            failures++; $display("FAIL if_hold: ack %b busy %b rdata %h want 0 0 85a5a5a5", a_if_ack, a_busy, a_rdata);
        end
    endtask

    task automatic test_ls_priority();
        a_if_req = 1'b1; a_if_addr = 30'h123;
        a_ls_req = 1'b1; a_ls_we = 1'b1; a_ls_addr = 30'h10; a_ls_wdata = 32'hDEADBEEF;
        tick();
        checks++;
        if ({a_mem_en, a_mem_we, a_owner} !== 4'b1110 || a_mem_addr !== 30'h10 || a_mem_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL ls_issue: en/we/owner %b addr %h wdata %h want 1110 10 deadbeef",
                {a_mem_en, a_mem_we, a_owner}, a_mem_addr, a_mem_wdata);
        end
        tick();
        checks++;
        if ({a_if_ack, a_ls_ack, a_ext_ack} !== 3'b010) begin
            failures++; $display("FAIL ls_ack: acks %b want 010", {a_if_ack, a_ls_ack, a_ext_ack});
        end
        a_ls_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({a_mem_en, a_mem_we, a_owner} !== 4'b1001 || a_mem_addr !== 30'h123) begin
            failures++; $display("FAIL if_after_ls: en/we/owner %b addr %h want 1001 123", {a_mem_en, a_mem_we, a_owner}, a_mem_addr);
        end
        tick();
        checks++;
        if ({a_if_ack, a_ls_ack, a_ext_ack} !== 3'b100 || a_rdata !== (32'h123 ^ 32'hA5A5A5A5)) begin
            failures++; $display("FAIL if_ack_t5: acks %b rdata %h want 100 %h", {a_if_ack, a_ls_ack, a_ext_ack}, a_rdata, 32'h123 ^ 32'hA5A5A5A5);
        end
        a_if_req = 1'b0;
        tick();
        a_ext_req = 1'b1; a_ext_we = 1'b0; a_ext_addr = 30'h10;
        tick();
        tick();
        checks++;
        if (a_ext_ack !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL ext_readback: ack %b rdata %h want 1 deadbeef", a_ext_ack, a_rdata);
        end
        a_ext_req = 1'b0;
        tick();
    endtask

    task automatic test_drop_after_grant();
        a_if_req = 1'b1; a_if_addr = 30'h44;
        tick();
        a_if_req = 1'b0;
        checks++;
        if (a_mem_en !== 1'b1 || a_owner !== 2'd1) begin
            failures++; $display("FAIL drop_issue: en %b owner %0d want 1 1", a_mem_en, a_owner);
        end
        tick();
        checks++;
        if (a_if_ack !== 1'b1 || a_rdata !== (32'h44 ^ 32'hA5A5A5A5)) begin
            failures++; $display("FAIL drop_ack: ack %b rdata %h want 1 %h", a_if_ack, a_rdata, 32'h44 ^ 32'hA5A5A5A5);
        end
        tick();
        tick();
        checks++;
        if ({a_mem_en, a_busy, a_owner, a_if_ack, a_ls_ack, a_ext_ack} !== 7'b0) begin
            failures++; $display("FAIL drop_idle: en/busy/owner/acks %b want 0000000",
                {a_mem_en, a_busy, a_owner, a_if_ack, a_ls_ack, a_ext_ack});
        end
    endtask

    task automatic test_ext_promotion();
        int ext_at;
        int ls_before;
        logic [1:0] own13;
        logic [DW-1:0] ext_rd;
        ext_at = -1; ls_before = 0; own13 = 2'd0; ext_rd = '0;
        a_ls_req = 1'b1; a_ls_we = 1'b0; a_ls_addr = 30'h200;
        a_ext_req = 1'b1; a_ext_we = 1'b0; a_ext_addr = 30'h77;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (a_ls_ack && ext_at < 0) ls_before++;
            if (a_ext_ack && ext_at < 0) begin
                ext_at = k; ext_rd = a_rdata; a_ext_req = 1'b0;
            end
            if (k == 13) own13 = a_owner;
            if (k == 14) a_ls_req = 1'b0;
        end
        checks++;
        if (ext_at != 11) begin
            failures++; $display("FAIL promo_ext_ack: cycle %0d want 11", ext_at);
        end
        checks++;
        if (ls_before != 3) begin
            failures++; $display("FAIL promo_ls_count: %0d want 3", ls_before);
        end
        checks++;
        if (own13 !== 2'd2 || ext_rd !== (32'h77 ^ 32'hA5A5A5A5)) begin
            failures++; $display("FAIL promo_resume: owner %0d rdata %h want 2 %h", own13, ext_rd, 32'h77 ^ 32'hA5A5A5A5);
        end
    endtask

    task automatic test_random();
        int free_at, grant_at, ack_at, win, wait_m, own;
        bit p_if, p_ls, p_ext, x_we, gen, exp_en;
        logic [AW-1:0] ad_if, ad_ls, ad_ext, x_addr;
        logic [DW-1:0] wd_ls, wd_ext, x_wd, x_rd;
        logic ls_w, ext_w;
        logic [2:0] exp_acks;
        free_at = cyc; grant_at = 0; ack_at = 0; win = 0; wait_m = 0;
        {p_if, p_ls, p_ext, x_we, ls_w, ext_w} = '0;
        {ad_if, ad_ls, ad_ext, x_addr} = '0;
        {wd_ls, wd_ext, x_wd, x_rd} = '0;
        model_mem[30'h10] = 32'hDEADBEEF;
        for (int n = 0; n < 400; n++) begin
            gen = (n < 300);
            own = (win != 0 && cyc > grant_at && cyc <= ack_at) ? win : 0;
            exp_en = (win != 0 && cyc == grant_at + 1);
            exp_acks = 3'b000;
            if (win != 0 && cyc == ack_at) exp_acks = (win == 1) ? 3'b100 : (win == 2) ? 3'b010 : 3'b001;
            checks++;
            if ({a_if_ack, a_ls_ack, a_ext_ack} !== exp_acks) begin
                failures++; $display("FAIL rnd_acks @%0d: %b want %b", cyc, {a_if_ack, a_ls_ack, a_ext_ack}, exp_acks);
            end
            checks++;
            if (a_mem_en !== exp_en || a_owner !== 2'(own) || a_busy !== (own != 0)) begin
                failures++; $display("FAIL rnd_ctrl @%0d: en %b owner %0d busy %b want %b %0d %b",
                    cyc, a_mem_en, a_owner, a_busy, exp_en, own, own != 0);
            end
            if (exp_en) begin
                checks++;
                if ({a_mem_we, a_mem_addr} !== {x_we, x_addr} || (x_we && a_mem_wdata !== x_wd)) begin
                    failures++; $display("FAIL rnd_issue @%0d: we %b addr %h wdata %h want %b %h %h",
                        cyc, a_mem_we, a_mem_addr, a_mem_wdata, x_we, x_addr, x_wd);
                end
            end
            if (exp_acks != 3'b000 && !x_we) begin
                checks++;
                if (a_rdata !== x_rd) begin
                    failures++; $display("FAIL rnd_rdata @%0d: %h want %h", cyc, a_rdata, x_rd);
                end
            end
            if (exp_acks != 3'b000) begin
                if (win == 1) p_if = 1'b0;
                if (win == 2) p_ls = 1'b0;
                if (win == 3) p_ext = 1'b0;
                win = 0;
            end
            if (gen) begin
                if (!p_if && $urandom_range(0, 99) < 40) begin
                    p_if = 1'b1; ad_if = 30'h100 + 30'($urandom_range(0, 15));
                end
                if (!p_ls && $urandom_range(0, 99) < 50) begin
                    p_ls = 1'b1; ad_ls = 30'h100 + 30'($urandom_range(0, 15));
                    ls_w = 1'($urandom_range(0, 1)); wd_ls = $urandom;
                end
                if (!p_ext && $urandom_range(0, 99) < 30) begin
                    p_ext = 1'b1; ad_ext = 30'h100 + 30'($urandom_range(0, 15));
                    ext_w = 1'($urandom_range(0, 1)); wd_ext = $urandom;
                end
            end
            a_if_req = p_if;   a_if_addr = ad_if;
            a_ls_req = p_ls;   a_ls_addr = ad_ls;   a_ls_we = ls_w;   a_ls_wdata = wd_ls;
            a_ext_req = p_ext; a_ext_addr = ad_ext; a_ext_we = ext_w; a_ext_wdata = wd_ext;
            if (win == 0 && cyc >= free_at && (p_if || p_ls || p_ext)) begin
                if (wait_m == int'(MAXW) && p_ext) win = 3;
                else if (p_ls)                     win = 2;
                else if (p_if)                     win = 1;
                else                               win = 3;
                grant_at = cyc; ack_at = cyc + 1 + LATA; free_at = cyc + 2 + LATA;
                case (win)
                    1: begin x_addr = ad_if;  x_we = 1'b0;  x_wd = '0;     end
                    2: begin x_addr = ad_ls;  x_we = ls_w;  x_wd = wd_ls;  end
                    default: begin x_addr = ad_ext; x_we = ext_w; x_wd = wd_ext; end
                endcase
                if (x_we) model_mem[x_addr] = x_wd;
                else x_rd = model_mem.exists(x_addr) ? model_mem[x_addr] : ({2'b00, x_addr} ^ 32'hA5A5A5A5);
            end
            if (!p_ext)                           wait_m = 0;
            else if (win == 3 && grant_at == cyc) wait_m = 0;
            else if (own == 3)                    wait_m = wait_m;
            else if (wait_m < int'(MAXW))         wait_m++;
            tick();
        end
        checks++;
        if (p_if || p_ls || p_ext || win != 0) begin
            failures++; $display("FAIL rnd_drain: pending %b%b%b win %0d want all served", p_if, p_ls, p_ext, win);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_ext_latency4();
        int en_cnt, en_at, busy_cnt, ack_cnt, ack_at;
        logic [DW-1:0] ack_rd;
        en_cnt = 0; en_at = -1; busy_cnt = 0; ack_cnt = 0; ack_at = -1; ack_rd = '0;
        b_ext_req = 1'b1; b_ext_we = 1'b0; b_ext_addr = 30'h3C;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (b_mem_en) begin en_cnt++; en_at = k; end
            if (b_busy) busy_cnt++;
            if (b_ext_ack) begin ack_cnt++; ack_at = k; ack_rd = b_rdata; b_ext_req = 1'b0; end
        end
        checks++;
        if (ack_cnt != 1 || ack_at != 5) begin
            failures++; $display("FAIL lat4_ack: count %0d cycle %0d want 1 5", ack_cnt, ack_at);
        end
        checks++;
        if (ack_rd !== (32'h3C ^ 32'hA5A5A5A5)) begin
            failures++; $display("FAIL lat4_rdata: %h want %h", ack_rd, 32'h3C ^ 32'hA5A5A5A5);
        end
        checks++;
        if (busy_cnt != 5) begin
            failures++; $display("FAIL lat4_busy: %0d cycles want 5", busy_cnt);
        end
        checks++;
        if (en_cnt != 1 || en_at != 1) begin
            failures++; $display("FAIL lat4_mem_en: count %0d cycle %0d want 1 1", en_cnt, en_at);
        end
    endtask

    task automatic test_reset_mid_access();
        int ack_cnt, ack_at, en_at;
        logic [DW-1:0] ack_rd;
        ack_cnt = 0; ack_at = -1; en_at = -1; ack_rd = '0;
        b_if_req = 1'b1; b_if_addr = 30'h99;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({b_busy, b_owner, b_if_ack, b_ls_ack, b_ext_ack} !== 6'b0 || b_rdata !== '0) begin
            failures++; $display("FAIL rstmid_state: busy/owner/acks %b rdata %h want 0 0",
                {b_busy, b_owner, b_if_ack, b_ls_ack, b_ext_ack}, b_rdata);
        end
        for (int k = 4; k <= 10; k++) begin
            tick();
            if (b_mem_en && en_at < 0) en_at = k;
            if (b_if_ack || b_ls_ack || b_ext_ack) begin
                ack_cnt++; ack_at = k; ack_rd = b_rdata; b_if_req = 1'b0;
            end
        end
        checks++;
        if (ack_cnt != 1 || ack_at != 8 || en_at != 4) begin
            failures++; $display("FAIL rstmid_regrant: acks %0d at %0d mem_en at %0d want 1 8 4", ack_cnt, ack_at, en_at);
        end
        checks++;
        if (ack_rd !== (32'h99 ^ 32'hA5A5A5A5)) begin
            failures++; $display("FAIL rstmid_rdata: %h want %h", ack_rd, 32'h99 ^ 32'hA5A5A5A5);
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1;
        hw_wr = '0;
        clear_inputs();
        test_reset();
        test_if_read();
        test_ls_priority();
        test_drop_after_grant();
        test_ext_promotion();
        test_random();
        test_ext_latency4();
        test_reset_mid_access();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
